// File: rtl/atm_session_initiator.sv
// ============================================================================
// atm_session_initiator : keypad-driven front end that assembles ATM core
// requests and captures the response. Optional lockout: ATM_FAIL_LOCK_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module atm_session_initiator #(
  parameter logic [2:0] OP_BALANCE     = 3'd3,
  parameter logic [2:0] OP_WITHDRAW    = 3'd4,
  parameter logic [2:0] OP_DEPOSIT     = 3'd5,
  parameter logic [2:0] OP_CHANGE_PIN  = 3'd6,
  parameter int         MAX_AMT_DIGITS = 8,
  parameter int         KEY_TIMEOUT    = 1000,
  parameter int         RESP_TIMEOUT   = 64
`ifdef ATM_FAIL_LOCK_EN
  ,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCK_CYCLES    = 5000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid_i,
  input  logic [3:0]  key_code_i,
  input  logic        req_ready_i,
  input  logic        resp_valid_i,
  input  logic        resp_success_i,
  input  logic [31:0] resp_balance_i,
  output logic        req_valid_o,
  output logic [3:0]  acc_num_o,
  output logic [15:0] pin_o,
  output logic [15:0] new_pin_o,
  output logic [31:0] amount_o,
  output logic [2:0]  operation_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        success_o,
  output logic [31:0] balance_o,
  output logic        key_err_o,
  output logic        timeout_o,
  output logic        locked_o
);

  localparam logic [3:0] K_ENTER  = 4'hA;
  localparam logic [3:0] K_CANCEL = 4'hB;
  localparam logic [3:0] K_CLEAR  = 4'hC;

  localparam int AC_W  = $clog2(MAX_AMT_DIGITS + 1);
  localparam int CNT_W = (AC_W > 3) ? AC_W : 3;
  localparam int KT_W  = $clog2(KEY_TIMEOUT + 1);
  localparam int RT_W  = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC    = 3'd1,
    S_PIN    = 3'd2,
    S_OP     = 3'd3,
    S_AMT    = 3'd4,
    S_NEWPIN = 3'd5,
    S_REQ    = 3'd6,
    S_WAIT   = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        acc_q, acc_d;
  logic [15:0]       pin_q, pin_d;
  logic [15:0]       newpin_q, newpin_d;
  logic [31:0]       amt_q, amt_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              success_q, success_d;
  logic [31:0]       balance_q, balance_d;
  logic              done_q, done_d;
  logic              key_err_q, key_err_d;
  logic              timeout_q, timeout_d;
  logic [KT_W-1:0]   key_tmr_q, key_tmr_d;
  logic [RT_W-1:0]   resp_tmr_q, resp_tmr_d;

  logic              w_is_digit;
  logic              w_in_key_state;
  logic              w_key_expire;
  logic              w_resp_expire;
  logic              w_locked;
  logic              go_idle;
  logic [15:0]       pin_cur, pin_nxt;

  assign w_is_digit     = (key_code_i <= 4'd9);
  assign w_in_key_state = (state_q inside {S_ACC, S_PIN, S_OP, S_AMT, S_NEWPIN});
  assign w_key_expire   = w_in_key_state && !key_valid_i &&
                          (key_tmr_q == KT_W'(KEY_TIMEOUT - 1));
  assign w_resp_expire  = (state_q == S_WAIT) && !resp_valid_i &&
                          (resp_tmr_q == RT_W'(RESP_TIMEOUT - 1));

  // Key timer only runs while the customer owes us a key; any key restarts it.
  assign key_tmr_d  = (w_in_key_state && !key_valid_i && !w_key_expire) ?
                      key_tmr_q + 1'b1 : '0;
  assign resp_tmr_d = ((state_q == S_WAIT) && !resp_valid_i && !w_resp_expire) ?
                      resp_tmr_q + 1'b1 : '0;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    pin_d     = pin_q;
    newpin_d  = newpin_q;
    amt_d     = amt_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    success_d = success_q;
    balance_d = balance_q;
    done_d    = 1'b0;
    key_err_d = 1'b0;
    timeout_d = 1'b0;
    go_idle   = 1'b0;
    pin_cur   = (state_q == S_NEWPIN) ? newpin_q : pin_q;
    pin_nxt   = pin_cur;

    case (state_q)
      S_IDLE: if (key_valid_i) begin
        if (w_locked || !w_is_digit) begin
          key_err_d = 1'b1;
        end else begin
          acc_d     = key_code_i;
          success_d = 1'b0;
          balance_d = '0;
          state_d   = S_ACC;
        end
      end
      S_ACC: if (key_valid_i) begin
        if (w_is_digit)                   acc_d = key_code_i;
        else if (key_code_i == K_ENTER)  begin state_d = S_PIN; cnt_d = '0; end
        else if (key_code_i == K_CANCEL) go_idle = 1'b1;
        else if (key_code_i == K_CLEAR)  acc_d = '0;
        else                              key_err_d = 1'b1;
      end
      S_PIN, S_NEWPIN: if (key_valid_i) begin
        if (w_is_digit) begin
          if (cnt_q < CNT_W'(4)) begin
            pin_nxt = {pin_cur[11:0], key_code_i};
            cnt_d   = cnt_q + 1'b1;
          end else begin
            key_err_d = 1'b1;
          end
        end else if (key_code_i == K_ENTER) begin
          if (cnt_q != CNT_W'(4)) begin
            key_err_d = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = (state_q == S_PIN) ? S_OP : S_REQ;
          end
        end else if (key_code_i == K_CANCEL) begin
          go_idle = 1'b1;
        end else if (key_code_i == K_CLEAR) begin
          pin_nxt = '0;
          cnt_d   = '0;
        end else begin
          key_err_d = 1'b1;
        end
        if (state_q == S_PIN) pin_d = pin_nxt;
        else                  newpin_d = pin_nxt;
      end
      S_OP: if (key_valid_i) begin
        case (key_code_i)
          4'd1:     begin op_d = OP_BALANCE;    state_d = S_REQ; end
          4'd2:     begin op_d = OP_WITHDRAW;   state_d = S_AMT;    cnt_d = '0; end
          4'd3:     begin op_d = OP_DEPOSIT;    state_d = S_AMT;    cnt_d = '0; end
          4'd4:     begin op_d = OP_CHANGE_PIN; state_d = S_NEWPIN; cnt_d = '0; end
          K_CANCEL: go_idle = 1'b1;
          default:  key_err_d = 1'b1;
        endcase
      end
      S_AMT: if (key_valid_i) begin
        if (w_is_digit) begin
          if (cnt_q < CNT_W'(MAX_AMT_DIGITS)) begin
            amt_d = amt_q * 32'd10 + {28'd0, key_code_i};
            cnt_d = cnt_q + 1'b1;
          end else begin
            key_err_d = 1'b1;
          end
        end else if (key_code_i == K_ENTER) begin
          if (amt_q == '0) key_err_d = 1'b1;
          else             state_d = S_REQ;
        end else if (key_code_i == K_CANCEL) begin
          go_idle = 1'b1;
        end else if (key_code_i == K_CLEAR) begin
          amt_d = '0;
          cnt_d = '0;
        end else begin
          key_err_d = 1'b1;
        end
      end
      S_REQ: if (req_ready_i) state_d = S_WAIT;
      S_WAIT: begin
        // A response outranks a simultaneous key; keys are never looked at here.
        if (resp_valid_i) begin
          success_d = resp_success_i;
          balance_d = resp_balance_i;
          done_d    = 1'b1;
          go_idle   = 1'b1;
        end else if (w_resp_expire) begin
          success_d = 1'b0;
          timeout_d = 1'b1;
          go_idle   = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (w_key_expire) begin
      timeout_d = 1'b1;
      go_idle   = 1'b1;
    end

    if (go_idle) begin
      state_d  = S_IDLE;
      acc_d    = '0;
      pin_d    = '0;
      newpin_d = '0;
      amt_d    = '0;
      op_d     = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      pin_q      <= '0;
      newpin_q   <= '0;
      amt_q      <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      success_q  <= 1'b0;
      balance_q  <= '0;
      done_q     <= 1'b0;
      key_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      key_tmr_q  <= '0;
      resp_tmr_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      pin_q      <= pin_d;
      newpin_q   <= newpin_d;
      amt_q      <= amt_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      success_q  <= success_d;
      balance_q  <= balance_d;
      done_q     <= done_d;
      key_err_q  <= key_err_d;
      timeout_q  <= timeout_d;
      key_tmr_q  <= key_tmr_d;
      resp_tmr_q <= resp_tmr_d;
    end
  end

`ifdef ATM_FAIL_LOCK_EN
  localparam int FC_W = $clog2(MAX_FAILS + 1);
  localparam int LT_W = $clog2(LOCK_CYCLES + 1);

  logic [FC_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [LT_W-1:0] lock_tmr_q, lock_tmr_d;
  logic            locked_q, locked_d;
  logic            w_fail_ev, w_pass_ev;

  // A response timeout is treated the same as a declined transaction.
  assign w_fail_ev = (state_q == S_WAIT) &&
                     ((resp_valid_i && !resp_success_i) || w_resp_expire);
  assign w_pass_ev = (state_q == S_WAIT) && resp_valid_i && resp_success_i;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    lock_tmr_d = lock_tmr_q;
    locked_d   = locked_q;
    if (locked_q) begin
      if (lock_tmr_q == LT_W'(LOCK_CYCLES - 1)) begin
        locked_d   = 1'b0;
        lock_tmr_d = '0;
        fail_cnt_d = '0;
      end else begin
        lock_tmr_d = lock_tmr_q + 1'b1;
      end
    end else if (w_fail_ev) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
      if (fail_cnt_q == FC_W'(MAX_FAILS - 1)) locked_d = 1'b1;
    end else if (w_pass_ev) begin
      fail_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_cnt_q <= '0;
      lock_tmr_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      lock_tmr_q <= lock_tmr_d;
      locked_q   <= locked_d;
    end
  end

  assign w_locked = locked_q;
`else
  assign w_locked = 1'b0;
`endif

  assign req_valid_o = (state_q == S_REQ);
  assign busy_o      = (state_q != S_IDLE);
  assign acc_num_o   = acc_q;
  assign pin_o       = pin_q;
  assign new_pin_o   = newpin_q;
  assign amount_o    = amt_q;
  assign operation_o = op_q;
  assign done_o      = done_q;
  assign success_o   = success_q;
  assign balance_o   = balance_q;
  assign key_err_o   = key_err_q;
  assign timeout_o   = timeout_q;
  assign locked_o    = w_locked;

endmodule

`default_nettype wire

// File: tb/tb_atm_session_initiator.sv
// ============================================================================
// tb_atm_session_initiator : directed bench with request/response scoreboard.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_atm_session_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_success;
  logic [31:0] resp_balance;
  logic        req_valid_o;
  logic [3:0]  acc_num_o;
  logic [15:0] pin_o;
  logic [15:0] new_pin_o;
  logic [31:0] amount_o;
  logic [2:0]  operation_o;
  logic        busy_o;
  logic        done_o;
  logic        success_o;
  logic [31:0] balance_o;
  logic        key_err_o;
  logic        timeout_o;
  logic        locked_o;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [15:0] npin;
    logic [31:0] amt;
    logic [2:0]  op;
  } req_t;

  typedef struct packed {
    logic        s;
    logic [31:0] bal;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  always #5 clk = ~clk;

  atm_session_initiator dut (
    .clk            (clk),
    .rst            (rst),
    .key_valid_i    (key_valid),
    .key_code_i     (key_code),
    .req_ready_i    (req_ready),
    .resp_valid_i   (resp_valid),
    .resp_success_i (resp_success),
    .resp_balance_i (resp_balance),
    .req_valid_o    (req_valid_o),
    .acc_num_o      (acc_num_o),
    .pin_o          (pin_o),
    .new_pin_o      (new_pin_o),
    .amount_o       (amount_o),
    .operation_o    (operation_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .success_o      (success_o),
    .balance_o      (balance_o),
    .key_err_o      (key_err_o),
    .timeout_o      (timeout_o),
    .locked_o       (locked_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] hexval(input logic [7:0] c);
    if (c >= 8'd48 && c <= 8'd57) return 4'(c - 8'd48);
    return 4'(c - 8'd55);
  endfunction

  // One key per cycle; returns the number of key_err pulses seen.
  task automatic press_str(input string s, output int errs);
    errs = 0;
    for (int i = 0; i < s.len(); i++) begin
      key_code  = hexval(s.getc(i));
      key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      if (key_err_o) errs++;
    end
  endtask

  task automatic exp_req(input logic [3:0] acc, input logic [15:0] pin,
                         input logic [15:0] npin, input logic [31:0] amt,
                         input logic [2:0] op);
    req_t e;
    e.acc = acc; e.pin = pin; e.npin = npin; e.amt = amt; e.op = op;
    req_q.push_back(e);
  endtask

  task automatic check_req(input string tag);
    req_t e;
    int   n = 0;
    while (!req_valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_req_valid"}, 32'(req_valid_o), 32'd1);
    chk({tag, "_sb_depth"}, req_q.size(), 32'd1);
    if (req_q.size() > 0) begin
      e = req_q.pop_front();
      chk({tag, "_acc"},     32'(acc_num_o),   32'(e.acc));
      chk({tag, "_pin"},     32'(pin_o),       32'(e.pin));
      chk({tag, "_new_pin"}, 32'(new_pin_o),   32'(e.npin));
      chk({tag, "_amount"},  amount_o,         e.amt);
      chk({tag, "_op"},      32'(operation_o), 32'(e.op));
    end
  endtask

  task automatic accept(input string tag);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    chk({tag, "_accepted"}, 32'({busy_o, req_valid_o}), 32'b10);
  endtask

  task automatic respond(input string tag, input logic s, input logic [31:0] bal);
    rsp_t e;
    e.s = s; e.bal = bal;
    rsp_q.push_back(e);
    resp_success = s;
    resp_balance = bal;
    resp_valid   = 1'b1;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    e = rsp_q.pop_front();
    chk({tag, "_success"}, 32'(success_o), 32'(e.s));
    chk({tag, "_balance"}, balance_o, e.bal);
    chk({tag, "_done_idle"}, 32'({done_o, busy_o}), 32'b10);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    int n;
    int unstable;
    rst = 1'b0; key_valid = 1'b0; key_code = '0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_success = 1'b0; resp_balance = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 32'({req_valid_o, busy_o, done_o, success_o, key_err_o, timeout_o, locked_o}), 32'd0);
    chk("rst_balance", balance_o, 32'd0);
    chk("rst_pins", {pin_o, new_pin_o}, 32'd0);
    chk("rst_amount", amount_o, 32'd0);
    chk("rst_acc_op", 32'({acc_num_o, operation_o}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Balance enquiry
    exp_req(4'd3, 16'h1234, 16'h0, 32'd0, 3'd3);
    press_str("3A1234A1", errs);
    chk("t1_no_key_err", errs, 32'd0);
    check_req("t1");
    accept("t1");
    respond("t1", 1'b1, 32'd1000);
    @(posedge clk); #1;
    chk("t1_done_one_cycle", 32'(done_o), 32'd0);
    chk("t1_success_held", 32'(success_o), 32'd1);

    // Withdrawal; first key of the session clears the previous result
    press_str("5", errs);
    chk("t2_success_cleared", 32'(success_o), 32'd0);
    chk("t2_balance_cleared", balance_o, 32'd0);
    exp_req(4'd5, 16'h0000, 16'h0, 32'd250, 3'd4);
    press_str("A0000A2250A", errs);
    chk("t2_no_key_err", errs, 32'd0);
    check_req("t2");
    accept("t2");
    respond("t2", 1'b1, 32'd750);
    @(posedge clk); #1;
    chk("t2_done_one_cycle", 32'(done_o), 32'd0);

    // Short PIN, then cancel
    press_str("8A123", errs);
    press_str("A", errs);
    chk("t3_short_pin_err", errs, 32'd1);
    chk("t3_pin_kept", 32'(pin_o), 32'h0123);
    chk("t3_still_busy", 32'(busy_o), 32'd1);
    press_str("B", errs);
    chk("t3_cancel_flags", 32'({busy_o, done_o, req_valid_o}), 32'd0);
    chk("t3_cancel_acc_pin", 32'({acc_num_o, pin_o}), 32'd0);

    // Fifth PIN digit, nine amount digits, stalled ready, response timeout
    press_str("7A98765", errs);
    chk("t4_fifth_pin_digit_err", errs, 32'd1);
    chk("t4_pin_kept", 32'(pin_o), 32'h9876);
    press_str("A3123456789", errs);
    chk("t4_ninth_digit_err", errs, 32'd1);
    chk("t4_amount", amount_o, 32'd12345678);
    exp_req(4'd7, 16'h9876, 16'h0, 32'd12345678, 3'd5);
    press_str("A", errs);
    check_req("t4");
    press_str("B", errs);
    chk("t4_key_ignored_in_req", errs, 32'd0);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!req_valid_o || acc_num_o != 4'd7 || pin_o != 16'h9876 ||
          amount_o != 32'd12345678 || operation_o != 3'd5) unstable++;
    end
    chk("t4_fields_stable", unstable, 32'd0);
    accept("t4");
    n = 0;
    while (!timeout_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_resp_timeout_cycles", n, 32'd64);
    chk("t4_abort_flags", 32'({busy_o, success_o, done_o}), 32'd0);
    chk("t4_fields_zeroed", amount_o, 32'd0);
    @(posedge clk); #1;
    chk("t4_timeout_pulse", 32'(timeout_o), 32'd0);

    // Key timeout in operation selection
    press_str("1A1111A", errs);
    n = 0;
    while (!timeout_o && n < 1100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_key_timeout_cycles", n, 32'd1000);
    chk("t5_idle_after_timeout", 32'({busy_o, acc_num_o, pin_o}), 32'd0);

    // Illegal keys, PIN change, response racing a key
    press_str("AE", errs);
    chk("t6_idle_non_digit_err", errs, 32'd2);
    chk("t6_still_idle", 32'(busy_o), 32'd0);
    press_str("2A4321A7", errs);
    chk("t6_bad_op_err", errs, 32'd1);
    exp_req(4'd2, 16'h4321, 16'h8765, 32'd0, 3'd6);
    press_str("48765A", errs);
    check_req("t6");
    accept("t6");
    rsp_q.push_back(rsp_t'{s: 1'b0, bal: 32'd42});
    key_code = 4'd5; key_valid = 1'b1;
    resp_success = 1'b0; resp_balance = 32'd42; resp_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; resp_valid = 1'b0;
    begin
      rsp_t e;
      e = rsp_q.pop_front();
      chk("t6_race_balance", balance_o, e.bal);
      chk("t6_race_success", 32'(success_o), 32'(e.s));
    end
    chk("t6_race_flags", 32'({done_o, key_err_o, busy_o}), 32'b100);

    // Zero amount rejected, CLEAR restarts the amount
    press_str("9A5555A200A", errs);
    chk("t7_zero_amount_err", errs, 32'd1);
    press_str("7C3", errs);
    chk("t7_amount_after_clear", amount_o, 32'd3);
    exp_req(4'd9, 16'h5555, 16'h0, 32'd3, 3'd4);
    press_str("A", errs);
    check_req("t7");
    accept("t7");
    respond("t7", 1'b1, 32'd97);

    // Asynchronous reset mid-session
    press_str("4A12", errs);
    #2 rst = 1'b0;
    #1;
    chk("t8_async_reset", 32'({busy_o, acc_num_o, pin_o}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

`ifdef ATM_FAIL_LOCK_EN
    for (int k = 0; k < 3; k++) begin
      press_str("1A1111A1", errs);
      accept("t9");
      respond("t9", 1'b0, 32'd5);
    end
    chk("t9_locked", 32'(locked_o), 32'd1);
    press_str("5", errs);
    chk("t9_locked_key_err", 32'({errs[0], busy_o}), 32'b10);
    n = 0;
    while (locked_o && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t9_lock_duration", 32'(n >= 4990 && n <= 5000), 32'd1);
    press_str("5", errs);
    chk("t9_unlocked_session", 32'({errs[0], busy_o}), 32'b01);
    press_str("B", errs);
`else
    chk("t9_locked_tied_low", 32'(locked_o), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
